// File: rtl/usb_rx_deserializer.sv
// USB full-speed receive bit engine: NRZI decode, SYNC detect, bit-unstuffing and
// LSB-first word assembly with registered one-cycle event pulses.
module usb_rx_deserializer #(
  parameter int unsigned DataBits = 8,
  parameter int unsigned StuffLen = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                d_in_i,
  input  logic                bit_strobe_i,
  input  logic                eop_i,
  output logic [DataBits-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                rx_start_o,
  output logic                rx_done_o,
  output logic                stuff_err_o,
  output logic                byte_err_o,
  output logic                busy_o
);

  localparam int unsigned BcW = $clog2(DataBits + 1);
  localparam int unsigned OcW = $clog2(StuffLen + 1);
  localparam logic [7:0] SyncWin = 8'h80;

  typedef enum logic [1:0] {StIdle, StData, StError} state_e;

  state_e              state_q, state_d;
  logic                prev_q, prev_d;
  logic [7:0]          window_q, window_d;
  logic [BcW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [OcW-1:0]      ones_cnt_q, ones_cnt_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_start_q, rx_start_d;
  logic                rx_done_q, rx_done_d;
  logic                stuff_err_q, stuff_err_d;
  logic                byte_err_q, byte_err_d;
  logic                busy_q, busy_d;

  logic                dec_bit;
  logic [7:0]          window_nxt;
  logic [DataBits-1:0] shift_nxt;

  // NRZI: no transition means a 1
  assign dec_bit    = (d_in_i == prev_q);
  assign window_nxt = {dec_bit, window_q[7:1]};
  assign shift_nxt  = {dec_bit, shift_q[DataBits-1:1]};

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    window_d    = window_q;
    bit_cnt_d   = bit_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_start_d  = 1'b0;
    rx_done_d   = 1'b0;
    stuff_err_d = 1'b0;
    byte_err_d  = 1'b0;

    // eop takes priority; a coincident strobe is dropped
    if (eop_i) begin
      prev_d = 1'b1;
      case (state_q)
        StData: begin
          if (bit_cnt_q == '0) begin
            rx_done_d = 1'b1;
          end else begin
            byte_err_d = 1'b1;
          end
          state_d = StIdle;
        end
        StError: state_d = StIdle;
        default: ;
      endcase
    end else if (bit_strobe_i) begin
      prev_d = d_in_i;
      case (state_q)
        StIdle: begin
          window_d = window_nxt;
          if (window_nxt == SyncWin) begin
            rx_start_d = 1'b1;
            state_d    = StData;
            bit_cnt_d  = '0;
            // the closing SYNC 1 already counts toward the stuffing run
            ones_cnt_d = OcW'(1);
          end
        end
        StData: begin
          if (ones_cnt_q == OcW'(StuffLen)) begin
            if (dec_bit) begin
              stuff_err_d = 1'b1;
              state_d     = StError;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            shift_d    = shift_nxt;
            ones_cnt_d = dec_bit ? ones_cnt_q + OcW'(1) : '0;
            if (bit_cnt_q == BcW'(DataBits - 1)) begin
              rx_data_d  = shift_nxt;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BcW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    if (state_d == StIdle && state_q != StIdle) begin
      window_d   = 8'hFF;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      prev_q      <= 1'b1;
      window_q    <= 8'hFF;
      bit_cnt_q   <= '0;
      ones_cnt_q  <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_start_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      byte_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      window_q    <= window_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_start_q  <= rx_start_d;
      rx_done_q   <= rx_done_d;
      stuff_err_q <= stuff_err_d;
      byte_err_q  <= byte_err_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_start_o  = rx_start_q;
  assign rx_done_o   = rx_done_q;
  assign stuff_err_o = stuff_err_q;
  assign byte_err_o  = byte_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Bench for usb_rx_deserializer: packets are built as transmitter-side bit streams
// (stuffing + NRZI encode) with the expected receive events attached per strobe.
module tb_usb_rx_deserializer;

  localparam logic [4:0] PStart = 5'b10000;
  localparam logic [4:0] PValid = 5'b01000;
  localparam logic [4:0] PDone  = 5'b00100;
  localparam logic [4:0] PStuff = 5'b00010;
  localparam logic [4:0] PByte  = 5'b00001;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_in, bit_strobe, eop;
  logic [7:0] rx_data;
  logic       rx_valid, rx_start, rx_done, stuff_err, byte_err, busy;

  always #5 clk = ~clk;

  usb_rx_deserializer #(
    .DataBits(8),
    .StuffLen(6)
  ) u_dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_in_i      (d_in),
    .bit_strobe_i(bit_strobe),
    .eop_i       (eop),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_start_o  (rx_start),
    .rx_done_o   (rx_done),
    .stuff_err_o (stuff_err),
    .byte_err_o  (byte_err),
    .busy_o      (busy)
  );

  typedef struct {
    logic       strobe;
    logic       eop;
    logic       lvl;
    logic [4:0] pulses;
    logic [7:0] data;
    logic       busy;
  } item_t;

  item_t      items[$];
  int         checks = 0;
  int         failures = 0;
  logic       tx_lvl;
  int         ones_run;
  int         cnt;
  logic [7:0] part;
  logic [7:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] p, input logic b);
    chk({tag, "_pulses"}, {27'd0, rx_start, rx_valid, rx_done, stuff_err, byte_err}, {27'd0, p});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_data});
  endtask

  task automatic push(input logic s, input logic e, input logic l, input logic [4:0] p,
                      input logic [7:0] d, input logic b);
    item_t it;
    it.strobe = s;
    it.eop    = e;
    it.lvl    = l;
    it.pulses = p;
    it.data   = d;
    it.busy   = b;
    items.push_back(it);
  endtask

  // One transmitted bit inside a packet; a 0 is a line transition
  task automatic add_bit(input logic b, input logic [4:0] p, input logic [7:0] d);
    if (!b) tx_lvl = ~tx_lvl;
    push(1'b1, 1'b0, tx_lvl, p, d, 1'b1);
  endtask

  task automatic add_data_bit(input logic b, input bit stuff_en);
    logic [4:0] p;
    p    = 5'd0;
    part = {b, part[7:1]};
    cnt++;
    if (cnt == 8) begin
      p   = PValid;
      cnt = 0;
    end
    add_bit(b, p, part);
    ones_run = b ? ones_run + 1 : 0;
    if (stuff_en && ones_run == 6) begin
      add_bit(1'b0, 5'd0, 8'd0);
      ones_run = 0;
    end
  endtask

  task automatic add_sync(input int pre);
    tx_lvl = 1'b1;
    repeat (pre) push(1'b1, 1'b0, 1'b1, 5'd0, 8'd0, 1'b0);
    repeat (7) begin
      tx_lvl = ~tx_lvl;
      push(1'b1, 1'b0, tx_lvl, 5'd0, 8'd0, 1'b0);
    end
    push(1'b1, 1'b0, tx_lvl, PStart, 8'd0, 1'b1);
    ones_run = 1;
    cnt      = 0;
    part     = 8'd0;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) add_data_bit(b[i], 1'b1);
  endtask

  task automatic add_eop(input logic [4:0] p);
    push(1'b0, 1'b1, 1'b1, p, 8'd0, 1'b0);
    tx_lvl = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  task automatic pkt_clean(input int nbytes);
    add_sync($urandom_range(0, 4));
    repeat (nbytes) add_byte(rand_byte());
    add_eop(PDone);
  endtask

  // e in 1..7: eop after e extra bits; e == 8: eop coincides with the 8th strobe
  task automatic pkt_trunc(input int nbytes, input int e);
    add_sync($urandom_range(0, 4));
    repeat (nbytes) add_byte(rand_byte());
    for (int i = 0; i < e; i++) begin
      if (i == 7) begin
        push(1'b1, 1'b1, ~tx_lvl, PByte, 8'd0, 1'b0);
        tx_lvl = 1'b1;
      end else begin
        add_data_bit(1'($urandom_range(0, 1)), 1'b1);
      end
    end
    if (e < 8) add_eop(PByte);
  endtask

  task automatic pkt_viol(input int nbytes);
    add_sync($urandom_range(0, 4));
    repeat (nbytes) add_byte(rand_byte());
    while (ones_run < 6) add_data_bit(1'b1, 1'b0);
    add_bit(1'b1, PStuff, 8'd0);
    repeat ($urandom_range(0, 5)) push(1'b1, 1'b0, 1'($urandom), 5'd0, 8'd0, 1'b1);
    add_eop(5'd0);
  endtask

  task automatic play();
    item_t it;
    while (items.size() > 0) begin
      it         = items.pop_front();
      d_in       = it.lvl;
      bit_strobe = it.strobe;
      eop        = it.eop;
      @(posedge clk);
      #1;
      bit_strobe = 1'b0;
      eop        = 1'b0;
      if (it.pulses[3]) exp_data = it.data;
      check_outputs("strobe", it.pulses, it.busy);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        check_outputs("gap", 5'd0, it.busy);
      end
    end
  endtask

  initial begin
    d_in       = 1'b1;
    bit_strobe = 1'b0;
    eop        = 1'b0;
    n_rst      = 1'b0;
    exp_data   = 8'd0;
    tx_lvl     = 1'b1;
    ones_run   = 0;
    cnt        = 0;
    part       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 5'd0, 1'b0);
    n_rst = 1'b1;

    repeat (20) push(1'b1, 1'b0, 1'b1, 5'd0, 8'd0, 1'b0);
    add_eop(5'd0);
    play();

    add_sync(3);
    add_byte(8'hA5);
    add_byte(8'h3C);
    add_eop(PDone);
    play();

    add_sync(1);
    add_byte(8'hFF);
    add_eop(PDone);
    add_sync(2);
    add_byte(8'hFF);
    add_byte(8'hFF);
    add_eop(PDone);
    play();

    pkt_viol(0);
    pkt_trunc(0, 3);
    pkt_clean(2);
    pkt_trunc(0, 8);
    play();

    // asynchronous reset in the middle of a byte
    add_sync(2);
    add_data_bit(1'b1, 1'b1);
    add_data_bit(1'b0, 1'b1);
    add_data_bit(1'b1, 1'b1);
    play();
    #2;
    n_rst    = 1'b0;
    exp_data = 8'd0;
    #1;
    check_outputs("abort", 5'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    pkt_clean(1);
    play();

    repeat (60) begin
      case ($urandom_range(0, 2))
        0:       pkt_clean($urandom_range(1, 3));
        1:       pkt_trunc($urandom_range(0, 2), $urandom_range(1, 8));
        default: pkt_viol($urandom_range(0, 2));
      endcase
      play();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive-side bit engine for the USB full-speed data path: turns a synchronized, sampled line level into bytes. It performs NRZI decode, SYNC detection, bit-unstuffing and LSB-first byte assembly. It delivers each byte with a one-cycle valid pulse to the packet decoder. It is the counterpart of the transmit path, whose parallel-to-serial shifter drives the line LSB-first and idles high (J).

## Interface
- DATA_BITS, 8, bits per assembled word
- STUFF_LEN, 6, consecutive decoded 1s after which a stuffed 0 is expected
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- d_in  in  1  synchronized line level; 1 = J (idle)
- bit_strobe  in  1  one-cycle pulse at the sample point of each bit period
- eop  in  1  one-cycle pulse from the line monitor when end-of-packet (SE0) is detected
- rx_data  out  DATA_BITS  last completed word; holds until the next word completes
- rx_valid  out  1  one-cycle pulse; rx_data was updated this cycle
- rx_start  out  1  one-cycle pulse; SYNC matched
- rx_done  out  1  one-cycle pulse; clean end of packet on a word boundary
- stuff_err  out  1  one-cycle pulse; a stuffing violation was detected
- byte_err  out  1  one-cycle pulse; EOP arrived mid-word
- busy  out  1  state != IDLE

## Operation
- NRZI decode (only on bit_strobe):
  - decoded bit = 1 if d_in == prev_level, else 0.
  - prev_level <= d_in.
  - prev_level resets to 1 and is forced to 1 on every eop.
- States: IDLE, DATA, ERROR.
- IDLE:
  - Each strobe shifts the decoded bit into the MSB of an 8-bit window register (right shift). The window resets to 8'hFF.
  - When the window becomes 8'b1000_0000 (seven 0s then a 1, in time order): pulse rx_start and go to DATA with bit_cnt=0, ones_cnt=1 (the final SYNC 1 counts toward stuffing).
  - eop in IDLE is ignored apart from the prev_level reset.
- DATA, on each strobe:
  - ones_cnt == STUFF_LEN: the bit is a stuff bit and is never shifted.
    - Decoded 0: drop it; ones_cnt <= 0.
    - Decoded 1: pulse stuff_err and go to ERROR.
  - Otherwise:
    - Shift the bit into the MSB of the shift register (LSB-first assembly) and increment bit_cnt.
    - ones_cnt <= bit ? ones_cnt+1 : 0.
  - When bit_cnt reaches DATA_BITS: rx_data <= assembled word, pulse rx_valid, bit_cnt <= 0.
  - ones_cnt carries across word boundaries.
- DATA, on eop:
  - bit_cnt == 0: pulse rx_done, go to IDLE.
  - Otherwise: pulse byte_err, discard the partial word, go to IDLE. No rx_valid and no rx_done.
- ERROR: ignore strobes until eop, then go to IDLE with no rx_done.
- Entering IDLE always reloads window = 8'hFF, bit_cnt = 0, ones_cnt = 0.
- eop and bit_strobe in the same cycle: eop wins and the strobe is discarded.
- Counter widths: bit_cnt holds 0..DATA_BITS; ones_cnt holds 0..STUFF_LEN. Neither counter wraps.

## Timing
- Reset values:
  - state IDLE
  - rx_data 0; rx_valid, rx_start, rx_done, stuff_err, byte_err and busy all 0
  - prev_level 1; window 8'hFF
- All outputs are registered. Each pulse is high exactly in the cycle after the clk edge that sampled the triggering strobe or eop, for one cycle.
- rx_valid and rx_data change together. rx_data is stable while rx_valid = 1 and afterwards, until the next rx_valid.
- busy rises with rx_start and falls in the cycle the exit pulse is asserted (rx_done, byte_err, or the eop that leaves ERROR).
- Throughput: one bit per strobe. Strobes may arrive on consecutive clocks; no minimum spacing is required.
- Reset asserted mid-packet: everything returns to reset values immediately (asynchronous). No pulse is emitted for the aborted word.

## Test plan
- Reset and idle: hold n_rst low, then drive idle J with 20 strobes -> every output stays 0 and busy = 0.
- Clean packet: NRZI-encoded SYNC, then bytes 0xA5 and 0x3C, then eop.
  - rx_start once.
  - rx_valid twice, with rx_data 0xA5 then 0x3C, each one cycle after the 8th data strobe of its byte.
  - rx_done once, one cycle after eop.
- Stuffing: SYNC + 0xFF with a stuffed 0 after the 5th data bit (9 strobes) -> rx_valid with rx_data = 0xFF after strobe 9, and no stuff_err. Repeat with 0xFF 0xFF to check ones_cnt carrying across the word boundary.
- Stuff violation: SYNC + seven consecutive decoded 1s -> stuff_err pulses on the 6th data strobe and there is no rx_valid. busy stays 1 until eop, then returns to 0 with no rx_done.
- Truncated word: SYNC + 3 data bits + eop -> byte_err pulse, no rx_valid, no rx_done, state IDLE. A following full packet is then received correctly.
- Simultaneous and abort cases:
  - eop in the same cycle as the 8th data strobe -> byte_err, no rx_valid.
  - n_rst pulsed mid-byte -> all outputs 0, and the next SYNC is detected normally.
